// File: rtl/trees_feeder.sv
// Front-end for a decision-tree ensemble. It streams model node words into the trees,
// packs feature words into a vector, launches inference and returns the class result.
module trees_feeder #(
  parameter int unsigned N_TREES          = 16,
  parameter int unsigned N_NODE_AND_LEAFS = 256,
  parameter int unsigned N_FEATURE        = 32,
  localparam int unsigned TreeW = (N_TREES > 1) ? $clog2(N_TREES) : 1,
  localparam int unsigned NodeW = (N_NODE_AND_LEAFS > 1) ? $clog2(N_NODE_AND_LEAFS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_load_model,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [63:0]               s_data,
  output logic                      load_trees,
  output logic [TreeW-1:0]          n_tree,
  output logic [NodeW-1:0]          n_node,
  output logic [63:0]               tree_nodes,
  output logic [N_FEATURE-1:0][31:0] features,
  output logic                      start,
  input  logic                      done,
  input  logic [7:0]                prediction,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [7:0]                m_data,
  output logic                      busy
);

  localparam int unsigned FeatWords = N_FEATURE / 2;
  localparam int unsigned FeatCntW  = (FeatWords > 1) ? $clog2(FeatWords) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoadModel,
    StLoadFeat,
    StStart,
    StWait,
    StOut
  } state_e;

  state_e                       state_q, state_d;
  logic [TreeW-1:0]             tree_cnt_q, tree_cnt_d;
  logic [NodeW-1:0]             node_cnt_q, node_cnt_d;
  logic [FeatCntW-1:0]          feat_cnt_q, feat_cnt_d;
  logic                         load_trees_q, load_trees_d;
  logic [TreeW-1:0]             n_tree_q, n_tree_d;
  logic [NodeW-1:0]             n_node_q, n_node_d;
  logic [63:0]                  tree_nodes_q, tree_nodes_d;
  logic [N_FEATURE-1:0][31:0]   features_q, features_d;
  logic                         m_valid_q, m_valid_d;
  logic [7:0]                   m_data_q, m_data_d;

  logic node_last, tree_last, feat_last;

  assign node_last = (node_cnt_q == NodeW'(N_NODE_AND_LEAFS - 1));
  assign tree_last = (tree_cnt_q == TreeW'(N_TREES - 1));
  assign feat_last = (feat_cnt_q == FeatCntW'(FeatWords - 1));

  always_comb begin
    state_d      = state_q;
    tree_cnt_d   = tree_cnt_q;
    node_cnt_d   = node_cnt_q;
    feat_cnt_d   = feat_cnt_q;
    load_trees_d = 1'b0;
    n_tree_d     = n_tree_q;
    n_node_d     = n_node_q;
    tree_nodes_d = tree_nodes_q;
    features_d   = features_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;

    unique case (state_q)
      StIdle: begin
        // The first feature word only wakes the FSM; it is consumed in StLoadFeat.
        if (cmd_load_model) begin
          state_d = StLoadModel;
        end else if (s_valid) begin
          state_d = StLoadFeat;
        end
      end
      StLoadModel: begin
        if (s_valid) begin
          load_trees_d = 1'b1;
          n_tree_d     = tree_cnt_q;
          n_node_d     = node_cnt_q;
          tree_nodes_d = s_data;
          if (node_last) begin
            node_cnt_d = '0;
            if (tree_last) begin
              tree_cnt_d = '0;
              state_d    = StIdle;
            end else begin
              tree_cnt_d = tree_cnt_q + 1'b1;
            end
          end else begin
            node_cnt_d = node_cnt_q + 1'b1;
          end
        end
      end
      StLoadFeat: begin
        if (s_valid) begin
          features_d[{feat_cnt_q, 1'b0}] = s_data[31:0];
          features_d[{feat_cnt_q, 1'b1}] = s_data[63:32];
          if (feat_last) begin
            feat_cnt_d = '0;
            state_d    = StStart;
          end else begin
            feat_cnt_d = feat_cnt_q + 1'b1;
          end
        end
      end
      StStart: begin
        state_d = StWait;
      end
      StWait: begin
        if (done) begin
          m_data_d  = prediction;
          m_valid_d = 1'b1;
          state_d   = StOut;
        end
      end
      StOut: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tree_cnt_q   <= '0;
      node_cnt_q   <= '0;
      feat_cnt_q   <= '0;
      load_trees_q <= 1'b0;
      n_tree_q     <= '0;
      n_node_q     <= '0;
      tree_nodes_q <= '0;
      features_q   <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      tree_cnt_q   <= tree_cnt_d;
      node_cnt_q   <= node_cnt_d;
      feat_cnt_q   <= feat_cnt_d;
      load_trees_q <= load_trees_d;
      n_tree_q     <= n_tree_d;
      n_node_q     <= n_node_d;
      tree_nodes_q <= tree_nodes_d;
      features_q   <= features_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
    end
  end

  assign s_ready    = (state_q == StLoadModel) || (state_q == StLoadFeat);
  assign start      = (state_q == StStart);
  assign busy       = (state_q != StIdle);
  assign load_trees = load_trees_q;
  assign n_tree     = n_tree_q;
  assign n_node     = n_node_q;
  assign tree_nodes = tree_nodes_q;
  assign features   = features_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;

endmodule
